mem_cmd_master: RTL and testbench

MEM_CMD_MASTER -- requirements
Module: mem_cmd_master

---
 rtl/mem_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_cmd_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_master.sv
// mem_cmd_master: queues read/write commands in a small FIFO and plays them
// out one at a time on a valid/ready memory port. Each command holds the port
// until the memory acknowledges it or until a timeout expires. Read data comes
// back as a one-cycle rsp_valid pulse. A timeout comes back as an err pulse.
module mem_cmd_master #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_wr_rd,
   input  logic [ADDR_WIDTH-1:0]         cmd_addr,
   input  logic [WIDTH-1:0]              cmd_wdata,
   output logic                          m_valid,
   output logic                          m_wr_rd,
   output logic [ADDR_WIDTH-1:0]         m_addr,
   output logic [WIDTH-1:0]              m_wdata,
   input  logic [WIDTH-1:0]              m_rdata,
   input  logic                          m_ready,
   output logic                          rsp_valid,
   output logic [WIDTH-1:0]              rsp_rdata,
   output logic                          err,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int TMO_W   = $clog2(TIMEOUT + 1);
   localparam int ENTRY_W = 1 + ADDR_WIDTH + WIDTH;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Counter increment that sticks at TIMEOUT instead of wrapping.
   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      logic [TMO_W-1:0] r;
      if (v >= TMO_MAX) begin
         r = TMO_MAX;
      end else begin
         r = v + TMO_W'(1);
      end
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic [ENTRY_W-1:0]     fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   busy_q, busy_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_wr_rd_q, m_wr_rd_d;
   logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
   logic [WIDTH-1:0]       m_wdata_q, m_wdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                   err_q, err_d;

   logic                   push;
   logic                   pop;
   logic                   fifo_nonempty;
   logic [ENTRY_W-1:0]     push_entry;
   logic [ENTRY_W-1:0]     head_entry;

   assign push          = cmd_valid & cmd_ready_q;
   assign fifo_nonempty = (count_q != ZERO_CNT);
   assign push_entry    = {cmd_wr_rd, cmd_addr, cmd_wdata};
   assign head_entry    = fifo_mem_q[rd_ptr_q];

   // Command FSM: issue from the FIFO head, wait for ack or timeout, then gap.
   // Leaving GAP with work queued issues straight away; that exit edge is the
   // idle issue decision, which keeps back-to-back commands at one per 3 cycles.
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      m_valid_d   = m_valid_q;
      m_wr_rd_d   = m_wr_rd_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      err_d       = 1'b0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (fifo_nonempty) begin
               pop                               = 1'b1;
               {m_wr_rd_d, m_addr_d, m_wdata_d}  = head_entry;
               m_valid_d                         = 1'b1;
               tmo_d                             = TMO_ZERO;
               state_d                           = S_REQ;
            end else begin
               m_valid_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_REQ: begin
            tmo_d = sat_inc(tmo_q);
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = S_GAP;
               if (!m_wr_rd_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = m_rdata;
               end else begin
                  rsp_valid_d = 1'b0;
               end
            end else if (tmo_q >= TMO_LAST) begin
               // Give up on this command; it is dropped, not retried.
               m_valid_d = 1'b0;
               err_d     = 1'b1;
               state_d   = S_GAP;
            end else begin
               m_valid_d = 1'b1;
            end
         end
         default: begin
            m_valid_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // FIFO pointer/occupancy bookkeeping and the registered status outputs.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      cmd_ready_d = (count_d != FULL_CNT);
      busy_d      = (count_d != ZERO_CNT) || (state_d != S_IDLE);
   end

   // FIFO storage: written at the tail on an accepted command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else if (push) begin
         fifo_mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         tmo_q       <= '0;
         m_valid_q   <= 1'b0;
         m_wr_rd_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         tmo_q       <= tmo_d;
         m_valid_q   <= m_valid_d;
         m_wr_rd_q   <= m_wr_rd_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         err_q       <= err_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;
   assign m_valid    = m_valid_q;
   assign m_wr_rd    = m_wr_rd_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mem_cmd_master.sv
// Bench for mem_cmd_master: a transaction-level model predicts every output
// each cycle, a simple memory answers the port, and directed scenarios pin
// hand-computed values.
module tb_mem_cmd_master;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr_rd = 1'b0;
   logic [3:0]  cmd_addr = 4'd0;
   logic [15:0] cmd_wdata = 16'd0;
   logic        m_valid, m_wr_rd;
   logic [3:0]  m_addr;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;
   logic        m_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        err, busy;
   logic [2:0]  fifo_count;
   logic        stall = 1'b0;

   int passed = 0;
   int total  = 0;

   mem_cmd_master #(.WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err), .busy(busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // Expected memory contents after the write of 0xA5A5 to address 3.
   function automatic logic [15:0] exp_mem(int a);
      if (a == 3) return 16'hA5A5;
      return 16'hC000 | 16'(a);
   endfunction

   // Memory: acks one edge after seeing m_valid, executes each sampled request.
   logic [15:0] mem [16];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'hC000 | 16'(i);
         m_ready <= 1'b0;
         m_rdata <= 16'd0;
      end else if (stall || !m_valid) begin
         m_ready <= 1'b0;
      end else begin
         m_ready <= 1'b1;
         if (m_wr_rd) mem[m_addr] <= m_wdata;
         else         m_rdata     <= mem[m_addr];
      end
   end

   // ---------------- transaction-level model ----------------
   typedef struct packed { logic wr; logic [3:0] addr; logic [15:0] data; } cmd_t;
   cmd_t        mq[$];
   cmd_t        cur = '0;
   cmd_t        newc;
   bit          on_port = 1'b0;
   bit          in_gap  = 1'b0;
   int          waited  = 0;
   bit          do_push;
   logic        e_rsp_valid = 1'b0;
   logic        e_err = 1'b0;
   logic [15:0] e_rdata = 16'd0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         mq.delete();
         cur = '0; on_port = 1'b0; in_gap = 1'b0; waited = 0;
         e_rsp_valid = 1'b0; e_err = 1'b0; e_rdata = 16'd0;
      end else begin
         do_push = cmd_valid && (mq.size() < DEPTH);
         newc.wr = cmd_wr_rd; newc.addr = cmd_addr; newc.data = cmd_wdata;
         e_rsp_valid = 1'b0;
         e_err = 1'b0;
         if (on_port) begin
            waited++;
            if (m_ready) begin
               on_port = 1'b0; in_gap = 1'b1;
               if (!cur.wr) begin e_rsp_valid = 1'b1; e_rdata = m_rdata; end
            end else if (waited >= TIMEOUT) begin
               on_port = 1'b0; in_gap = 1'b1; e_err = 1'b1;
            end
         end else begin
            in_gap = 1'b0;
            if (mq.size() > 0) begin
               cur = mq.pop_front(); on_port = 1'b1; waited = 0;
            end
         end
         if (do_push) mq.push_back(newc);
      end
   end

   // Compare every output against the model away from the clock edge.
   initial forever begin
      @(negedge clk);
      chk("cmp_m_valid",    m_valid,    on_port);
      chk("cmp_m_wr_rd",    m_wr_rd,    cur.wr);
      chk("cmp_m_addr",     m_addr,     cur.addr);
      chk("cmp_m_wdata",    m_wdata,    cur.data);
      chk("cmp_rsp_valid",  rsp_valid,  e_rsp_valid);
      chk("cmp_rsp_rdata",  rsp_rdata,  e_rdata);
      chk("cmp_err",        err,        e_err);
      chk("cmp_fifo_count", fifo_count, mq.size());
      chk("cmp_cmd_ready",  cmd_ready,  mq.size() < DEPTH);
      chk("cmp_busy",       busy,       (mq.size() > 0) || on_port || in_gap);
   end

   // Observation counters used by the directed checks.
   int          cyc = 0, mv_cycles = 0, err_cnt = 0, streak = 0, max_streak = 0;
   int          max_count = 0;
   logic [15:0] rsp_q[$];
   int          rsp_t[$];
   initial forever begin
      @(posedge clk); #1;
      cyc++;
      if (m_valid) begin mv_cycles++; streak++; end
      else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (rsp_valid) begin rsp_q.push_back(rsp_rdata); rsp_t.push_back(cyc); end
      if (err) err_cnt++;
   end

   // Offer one command from a negedge until accepted (bounded).
   task automatic push(input logic wr, input logic [3:0] a, input logic [15:0] d);
      int n = 0;
      logic acc = 1'b0;
      cmd_valid = 1'b1; cmd_wr_rd = wr; cmd_addr = a; cmd_wdata = d;
      while (!acc && n < 200) begin
         acc = cmd_ready;
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      chk("push_accept", acc, 1'b1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      chk("idle_reached", busy, 1'b0);
   endtask

   int mv0, r0, e0;
   int exp_addr[6] = '{1, 2, 4, 8, 9, 10};

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_wr_rd", m_wr_rd, 1'b0);
      chk("rst_m_addr", m_addr, 4'd0);
      chk("rst_m_wdata", m_wdata, 16'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 16'd0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fifo_count", fifo_count, 3'd0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("cmd_ready_after_rst", cmd_ready, 1'b1);

      // Write then read back address 3.
      mv0 = mv_cycles; r0 = rsp_q.size();
      push(1'b1, 4'd3, 16'hA5A5);
      push(1'b0, 4'd3, 16'h0000);
      wait_idle();
      chk("wr_rd_mvalid_cycles", mv_cycles - mv0, 32'd4);
      chk("wr_rd_rsp_count", rsp_q.size() - r0, 32'd1);
      if (rsp_q.size() > r0) chk("wr_rd_rsp_data", rsp_q[r0], 16'hA5A5);

      // Fill the FIFO behind a stalled memory, then drain with a push waiting at full.
      r0 = rsp_q.size();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) push(1'b0, 4'(exp_addr[i]), 16'h0000);
      chk("full_fifo_count", fifo_count, 3'd4);
      chk("full_cmd_ready", cmd_ready, 1'b0);
      fork
         push(1'b0, 4'd10, 16'h0000);
         begin repeat (2) @(negedge clk); stall = 1'b0; end
      join
      wait_idle();
      chk("drain_rsp_count", rsp_q.size() - r0, 32'd6);
      for (int i = 0; i < 6; i++)
         if (r0 + i < rsp_q.size()) chk("drain_order", rsp_q[r0 + i], exp_mem(exp_addr[i]));
      chk("max_fifo_count", max_count, 32'd4);

      // Timeout: memory silent for 20 cycles.
      r0 = rsp_q.size(); e0 = err_cnt;
      stall = 1'b1;
      push(1'b0, 4'd7, 16'h0000);
      repeat (20) @(negedge clk);
      stall = 1'b0;
      wait_idle();
      chk("timeout_err_count", err_cnt - e0, 32'd1);
      chk("timeout_mvalid_cycles", max_streak, 32'd15);
      chk("timeout_no_rsp", rsp_q.size() - r0, 32'd0);
      push(1'b0, 4'd12, 16'h0000);
      wait_idle();
      chk("after_timeout_rsp_count", rsp_q.size() - r0, 32'd1);
      if (rsp_q.size() > r0) chk("after_timeout_rsp_data", rsp_q[r0], exp_mem(12));
      chk("after_timeout_err_count", err_cnt - e0, 32'd1);

      // Sixteen back-to-back reads.
      r0 = rsp_q.size();
      for (int i = 0; i < 16; i++) push(1'b0, 4'(i), 16'h0000);
      wait_idle();
      chk("b2b_rsp_count", rsp_q.size() - r0, 32'd16);
      for (int i = 0; i < 16; i++)
         if (r0 + i < rsp_q.size()) chk("b2b_data", rsp_q[r0 + i], exp_mem(i));
      for (int i = 0; i < 15; i++)
         if (r0 + i + 1 < rsp_t.size()) chk("b2b_spacing", rsp_t[r0 + i + 1] - rsp_t[r0 + i], 32'd3);

      // Asynchronous reset while a read waits in REQ.
      stall = 1'b1;
      push(1'b0, 4'd5, 16'h0000);
      push(1'b0, 4'd6, 16'h0000);
      r0 = rsp_q.size(); e0 = err_cnt;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("async_rst_m_valid", m_valid, 1'b0);
      chk("async_rst_fifo_count", fifo_count, 3'd0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_cmd_ready", cmd_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      stall = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);
      repeat (10) @(negedge clk);
      chk("post_rst_no_rsp", rsp_q.size() - r0, 32'd0);
      chk("post_rst_no_err", err_cnt - e0, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
